rv32i_dmem_arbiter: RTL and testbench

- Shares the single data-memory port (syncDualPortRam data side) and the ioInterface between two requesters.
- Requester M is the pipeline MEM stage; requester L is the program loader/debug port.
- Decodes each access to RAM or IO by address and sequences the RAM read latency and the variable IO ack latency.
- Generates the MEM-stage stall.

---
 rtl/rv32i_dmem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_rv32i_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dmem_arbiter.sv
// Data-memory / IO arbiter for the rv32i core: shares one RAM port and the IO bus
// between the MEM stage (M) and the loader/debug port (L), and generates the MEM stall.
module rv32i_dmem_arbiter #(
   parameter logic [29:0] IO_BASE    = 30'h3FFF_C000,
   parameter logic [29:0] IO_MASK    = 30'h3FFF_C000,
   parameter int unsigned IO_TIMEOUT = 16,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_req,
   input  logic        m_we,
   input  logic [29:0] m_addr,
   input  logic [3:0]  m_be,
   input  logic [31:0] m_wdata,
   output logic        m_gnt,
   output logic        m_rvalid,
   output logic [31:0] m_rdata,
   output logic        m_stall,
   input  logic        l_req,
   input  logic        l_we,
   input  logic [29:0] l_addr,
   input  logic [3:0]  l_be,
   input  logic [31:0] l_wdata,
   output logic        l_gnt,
   output logic        l_rvalid,
   output logic [31:0] l_rdata,
   output logic        d_we,
   output logic [29:0] d_addr,
   output logic [3:0]  d_be,
   output logic [31:0] d_wdata,
   input  logic [31:0] d_rdata,
   output logic        io_req,
   output logic        io_we,
   output logic [29:0] io_addr,
   output logic [3:0]  io_be,
   output logic [31:0] io_wdata,
   input  logic [31:0] io_rdata,
   input  logic        io_ack,
   output logic        err_timeout
);

   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam int unsigned CW = $clog2(IO_TIMEOUT);

   typedef enum logic [1:0] {IDLE, RAM_RD, IO_WAIT} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] burst_q;
   logic [CW-1:0] cnt_q;
   logic          own_m_q, we_q;
   logic [29:0]   addr_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic          m_rvalid_q, l_rvalid_q, err_q;
   logic [31:0]   m_rdata_q, l_rdata_q;

   logic          m_wins, l_wins, w_we, w_io;
   logic [29:0]   w_addr;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic          rsp_d, tout_d, ram_rsp;
   logic [31:0]   rsp_data;

   // Arbitration, address decode, next state and same-cycle bus drive
   always_comb begin
      m_wins   = m_req & (~l_req | (burst_q == BW'(MAX_BURST)));
      l_wins   = l_req & ~m_wins;
      w_we     = m_wins ? m_we    : l_we;
      w_addr   = m_wins ? m_addr  : l_addr;
      w_be     = m_wins ? m_be    : l_be;
      w_wdata  = m_wins ? m_wdata : l_wdata;
      w_io     = ((w_addr & IO_MASK) == IO_BASE);

      state_d  = state_q;
      m_gnt    = 1'b0;
      l_gnt    = 1'b0;
      d_we     = 1'b0;
      d_addr   = '0;
      d_be     = '0;
      d_wdata  = '0;
      io_req   = 1'b0;
      io_we    = 1'b0;
      io_addr  = '0;
      io_be    = '0;
      io_wdata = '0;
      rsp_d    = 1'b0;
      tout_d   = 1'b0;
      rsp_data = '0;

      unique case (state_q)
         IDLE: begin
            // reset gating keeps grants low while reset is held
            if (reset && (m_wins || l_wins)) begin
               m_gnt = m_wins;
               l_gnt = l_wins;
               if (w_io) begin
                  io_req   = 1'b1;
                  io_we    = w_we;
                  io_addr  = w_addr;
                  io_be    = w_be;
                  io_wdata = w_wdata;
                  state_d  = IO_WAIT;
               end else begin
                  d_addr = w_addr;
                  d_be   = w_be;
                  if (w_we) begin
                     d_we    = 1'b1;
                     d_wdata = w_wdata;
                  end else begin
                     state_d = RAM_RD;
                  end
               end
            end
         end
         RAM_RD: begin
            d_addr  = addr_q;
            d_be    = be_q;
            state_d = IDLE;
         end
         IO_WAIT: begin
            io_req   = 1'b1;
            io_we    = we_q;
            io_addr  = addr_q;
            io_be    = be_q;
            io_wdata = wdata_q;
            // ack beats a coincident timeout
            if (io_ack) begin
               rsp_d    = ~we_q;
               rsp_data = io_rdata;
               state_d  = IDLE;
            end else if (cnt_q == CW'(IO_TIMEOUT - 1)) begin
               rsp_d    = ~we_q;
               tout_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ram_rsp     = (state_q == RAM_RD);
   assign m_rvalid    = m_rvalid_q | (ram_rsp & own_m_q);
   assign l_rvalid    = l_rvalid_q | (ram_rsp & ~own_m_q);
   assign m_rdata     = (ram_rsp & own_m_q)  ? d_rdata : m_rdata_q;
   assign l_rdata     = (ram_rsp & ~own_m_q) ? d_rdata : l_rdata_q;
   assign err_timeout = err_q;
   // M read in flight stalls from its grant until its rvalid
   assign m_stall     = (m_req & ~m_gnt) | (m_gnt & ~m_we)
                      | (own_m_q & ~we_q & (state_q != IDLE) & ~m_rvalid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         burst_q    <= '0;
         cnt_q      <= '0;
         own_m_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         m_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
         m_rdata_q  <= '0;
         l_rdata_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (!m_req || m_gnt)
            burst_q <= '0;
         else if (l_gnt && (burst_q != BW'(MAX_BURST)))
            burst_q <= burst_q + 1'b1;
         // the grant cycle counts as the first io_req cycle
         cnt_q <= (state_q == IO_WAIT) ? cnt_q + 1'b1 : CW'(1);
         if (m_gnt || l_gnt) begin
            own_m_q <= m_gnt;
            we_q    <= w_we;
            addr_q  <= w_addr;
            be_q    <= w_be;
            wdata_q <= w_wdata;
         end
         m_rvalid_q <= rsp_d & own_m_q;
         l_rvalid_q <= rsp_d & ~own_m_q;
         err_q      <= tout_d;
         if (rsp_d) begin
            if (own_m_q) m_rdata_q <= rsp_data;
            else         l_rdata_q <= rsp_data;
         end else if (ram_rsp) begin
            if (own_m_q) m_rdata_q <= d_rdata;
            else         l_rdata_q <= d_rdata;
         end
      end
   end

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Bench for rv32i_dmem_arbiter: RAM model, hand-driven IO device, read-response scoreboard.
module tb_rv32i_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        m_req, m_we, m_gnt, m_rvalid, m_stall;
   logic [29:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wdata, m_rdata;
   logic        l_req, l_we, l_gnt, l_rvalid;
   logic [29:0] l_addr;
   logic [3:0]  l_be;
   logic [31:0] l_wdata, l_rdata;
   logic        d_we;
   logic [29:0] d_addr;
   logic [3:0]  d_be;
   logic [31:0] d_wdata, d_rdata;
   logic        io_req, io_we, io_ack, err_timeout;
   logic [29:0] io_addr;
   logic [3:0]  io_be;
   logic [31:0] io_wdata, io_rdata;

   typedef struct {
      bit          is_m;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_chk;
   int          n_pass;
   logic        preload;
   logic [31:0] mem [256];

   rv32i_dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_stall(m_stall),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_be(l_be), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_be(io_be),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
      .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: byte-enabled write, read data one cycle after the address
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= {24'h0, 8'(i)};
         mem[8'h10] <= 32'hCAFE_F00D;
         mem[8'h21] <= 32'h1111_2222;
      end else if (d_we) begin
         for (int b = 0; b < 4; b++)
            if (d_be[b]) mem[d_addr[7:0]][8*b +: 8] <= d_wdata[8*b +: 8];
      end
      d_rdata <= mem[d_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
   endtask

   task automatic rsp(input bit is_m, input logic [31:0] d);
      exp_t e;
      if (sb.size() == 0) begin
         chk(is_m ? "m_rsp_pending" : "l_rsp_pending", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk("rsp_owner", 32'(is_m), 32'(e.is_m));
         chk(is_m ? "m_rdata" : "l_rdata", d, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (m_rvalid === 1'b1) rsp(1'b1, m_rdata);
         if (l_rvalid === 1'b1) rsp(1'b0, l_rdata);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit is_m, input logic we, input logic [29:0] a,
                          input logic [3:0] be, input logic [31:0] d);
      if (is_m) begin
         m_req = 1'b1; m_we = we; m_addr = a; m_be = be; m_wdata = d;
      end else begin
         l_req = 1'b1; l_we = we; l_addr = a; l_be = be; l_wdata = d;
      end
   endtask

   task automatic ram_read(input bit is_m, input logic [29:0] a, input logic [31:0] exp);
      step();
      set_req(is_m, 1'b0, a, 4'hF, 32'h0);
      sb.push_back('{is_m, exp});
      @(negedge clk);
      chk("rd_gnt", 32'(is_m ? m_gnt : l_gnt), 32'd1);
      chk("rd_io_req", 32'(io_req), 32'd0);
      chk("rd_d_addr", 32'(d_addr), 32'(a));
      step();
      m_req = 1'b0; l_req = 1'b0;
      @(negedge clk);
      chk("rd_rvalid", 32'(is_m ? m_rvalid : l_rvalid), 32'd1);
   endtask

   task automatic ram_write(input bit is_m, input logic [29:0] a, input logic [3:0] be,
                            input logic [31:0] d);
      step();
      set_req(is_m, 1'b1, a, be, d);
      @(negedge clk);
      chk("wr_gnt", 32'(is_m ? m_gnt : l_gnt), 32'd1);
      chk("wr_d_we", 32'(d_we), 32'd1);
      chk("wr_d_addr", 32'(d_addr), 32'(a));
      chk("wr_d_wdata", d_wdata, d);
      step();
      m_req = 1'b0; l_req = 1'b0;
   endtask

   // IO access; ack_at is the cycle index (0 = grant cycle) of io_ack, -1 for never
   task automatic io_access(input bit is_m, input logic we, input logic [29:0] a,
                            input int ack_at, input logic [31:0] ack_data);
      int io_cycles = 0;
      int err_cnt   = 0;
      int err_cyc   = -1;
      int rv_cyc    = -1;
      step();
      set_req(is_m, we, a, 4'hF, 32'h5A5A_0000);
      if (!we) sb.push_back('{is_m, (ack_at >= 0) ? ack_data : 32'h0});
      for (int c = 0; c < 24; c++) begin
         if (c == ack_at) begin
            io_ack = 1'b1; io_rdata = ack_data;
         end
         @(negedge clk);
         if (c == 0) begin
            chk("io_gnt", 32'(is_m ? m_gnt : l_gnt), 32'd1);
            chk("io_addr", 32'(io_addr), 32'(a));
            chk("io_we", 32'(io_we), 32'(we));
            chk("io_d_we", 32'(d_we), 32'd0);
         end
         if (c == 1 && is_m && !we) chk("io_m_stall", 32'(m_stall), 32'd1);
         if (io_req) io_cycles++;
         if (err_timeout) begin
            err_cnt++; err_cyc = c;
         end
         if (is_m ? m_rvalid : l_rvalid) rv_cyc = c;
         step();
         m_req = 1'b0; l_req = 1'b0; io_ack = 1'b0; io_rdata = 32'hBAD0_BAD0;
      end
      chk("io_req_cycles", 32'(io_cycles), 32'((ack_at >= 0) ? ack_at + 1 : 16));
      chk("err_count", 32'(err_cnt), 32'((ack_at >= 0) ? 0 : 1));
      chk("err_cycle", 32'(err_cyc), 32'((ack_at >= 0) ? -1 : 16));
      chk("rvalid_cycle", 32'(rv_cyc),
          32'(we ? -1 : ((ack_at >= 0) ? ack_at + 1 : 16)));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_pass = 0;
      reset = 1'b0; preload = 1'b1;
      m_req = 0; m_we = 0; m_addr = '0; m_be = '0; m_wdata = '0;
      l_req = 0; l_we = 0; l_addr = '0; l_be = '0; l_wdata = '0;
      io_ack = 0; io_rdata = '0;

      // reset state
      @(negedge clk);
      chk("rst_m_gnt", 32'(m_gnt), 0);
      chk("rst_l_gnt", 32'(l_gnt), 0);
      chk("rst_io_req", 32'(io_req), 0);
      chk("rst_m_rvalid", 32'(m_rvalid), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_m_rdata", m_rdata, 0);
      chk("rst_l_rdata", l_rdata, 0);
      step();
      reset = 1'b1; preload = 1'b0;

      // M RAM read with stall profile
      step();
      set_req(1'b1, 1'b0, 30'h10, 4'hF, 32'h0);
      sb.push_back('{1'b1, 32'hCAFE_F00D});
      @(negedge clk);
      chk("t1_m_gnt", 32'(m_gnt), 1);
      chk("t1_stall_c0", 32'(m_stall), 1);
      chk("t1_d_addr", 32'(d_addr), 32'h10);
      step();
      m_req = 1'b0;
      @(negedge clk);
      chk("t1_rvalid_c1", 32'(m_rvalid), 1);
      chk("t1_stall_c1", 32'(m_stall), 0);
      step();
      @(negedge clk);
      chk("t1_rvalid_c2", 32'(m_rvalid), 0);
      chk("t1_rdata_hold", m_rdata, 32'hCAFE_F00D);

      // burst limit: L gets 4 grants, then M
      step();
      set_req(1'b1, 1'b1, 30'h20, 4'hF, 32'h1234_5678);
      set_req(1'b0, 1'b1, 30'h30, 4'hF, 32'hA000_0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("burst_l_gnt", 32'(l_gnt), 32'(i < 4));
         chk("burst_m_gnt", 32'(m_gnt), 32'(i == 4));
         chk("burst_d_addr", 32'(d_addr), (i < 4) ? 32'h30 + 32'(i) : 32'h20);
         step();
         if (i < 4) begin
            l_addr = 30'h31 + 30'(i); l_wdata = 32'hA000_0001 + 32'(i);
         end
      end
      // burst count cleared by the M grant: L wins again over a waiting M
      set_req(1'b1, 1'b1, 30'h21, 4'b0011, 32'hFFFF_BEEF);
      @(negedge clk);
      chk("burst_clr_l_gnt", 32'(l_gnt), 1);
      chk("burst_clr_m_gnt", 32'(m_gnt), 0);
      step();
      l_req = 1'b0;
      @(negedge clk);
      chk("burst_m_after", 32'(m_gnt), 1);
      chk("burst_d_be", 32'(d_be), 32'h3);
      step();
      m_req = 1'b0;

      ram_read(1'b0, 30'h33, 32'hA000_0003);
      ram_read(1'b0, 30'h34, 32'hA000_0004);
      ram_read(1'b1, 30'h20, 32'h1234_5678);
      ram_read(1'b1, 30'h21, 32'h1111_BEEF);
      ram_read(1'b1, 30'h3FFF_BFFF, 32'h0000_00FF);

      // IO: read with ack, write timeout, ack on the timeout limit, read timeout
      io_access(1'b1, 1'b0, 30'h3FFF_C001, 2, 32'h55);
      io_access(1'b0, 1'b1, 30'h3FFF_C002, -1, 32'h0);
      io_access(1'b1, 1'b0, 30'h3FFF_C003, 15, 32'h77);
      io_access(1'b0, 1'b0, 30'h3FFF_C004, -1, 32'h0);
      ram_write(1'b0, 30'h50, 4'hF, 32'h0000_0050);

      // stray ack in IDLE
      step();
      io_ack = 1'b1; io_rdata = 32'h1;
      @(negedge clk);
      chk("stray_io_req", 32'(io_req), 0);
      step();
      io_ack = 1'b0;
      @(negedge clk);
      chk("stray_err", 32'(err_timeout), 0);

      // reset in the middle of an IO read
      step();
      set_req(1'b1, 1'b0, 30'h3FFF_C005, 4'hF, 32'h0);
      @(negedge clk);
      chk("mid_m_gnt", 32'(m_gnt), 1);
      step();
      m_req = 1'b0;
      set_req(1'b0, 1'b1, 30'h51, 4'hF, 32'h0000_0051);
      step();
      #2 reset = 1'b0;
      #1;
      chk("mid_io_req", 32'(io_req), 0);
      chk("mid_l_gnt", 32'(l_gnt), 0);
      chk("mid_m_rvalid", 32'(m_rvalid), 0);
      chk("mid_m_rdata", m_rdata, 0);
      step();
      reset = 1'b1; l_req = 1'b0;
      ram_write(1'b1, 30'h40, 4'hF, 32'h0BAD_F00D);
      ram_read(1'b1, 30'h40, 32'h0BAD_F00D);

      step();
      @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
